// File: rtl/button_reset_conditioner_if.sv
// Button/reset conditioner signal bundle.
// The conditioner side uses the master modport: it samples the raw button and
// drives the conditioned reset, event pulses and debounced level.
interface button_reset_conditioner_if;
   logic BTN_N;      // raw pushbutton, active low, asynchronous to the clock
   logic RST_OUT_N;  // stretched active-low reset for downstream blocks
   logic PRESS;      // one-cycle pulse on an accepted press
   logic RELEASE;    // one-cycle pulse on an accepted release
   logic DOWN;       // debounced level, 1 = pressed

   modport master (
      input  BTN_N,
      output RST_OUT_N,
      output PRESS,
      output RELEASE,
      output DOWN
   );

   modport slave (
      output BTN_N,
      input  RST_OUT_N,
      input  PRESS,
      input  RELEASE,
      input  DOWN
   );
endinterface

// File: rtl/button_reset_conditioner.sv
// Pushbutton conditioner: synchronises and debounces the raw active-low button,
// emits press/release pulses and a debounced level, and stretches an active-low
// reset both after RESET release and after every accepted press.
module button_reset_conditioner #(
   parameter int unsigned CLKFREQ         = 32'd25000000,
   parameter int unsigned DEBOUNCE_CYCLES = 32'd250000,
   parameter int unsigned STRETCH_CYCLES  = 32'd2500000
) (
   input  logic                         CLK,
   input  logic                         RESET,
   button_reset_conditioner_if.master   bus
);

   // Both counters compare against their terminal value, one less than the count.
   localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 32'd1);
   localparam logic [31:0] STR_LAST = 32'(STRETCH_CYCLES - 32'd1);

   // Zero-length windows would make the counters wrap; refuse them at elaboration.
   if ((DEBOUNCE_CYCLES == 32'd0) || (STRETCH_CYCLES == 32'd0) || (CLKFREQ == 32'd0)) begin : g_param_check
      $error("button_reset_conditioner: CLKFREQ, DEBOUNCE_CYCLES and STRETCH_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      S_UP      = 2'd0,
      S_DN_WAIT = 2'd1,
      S_DOWN    = 2'd2,
      S_UP_WAIT = 2'd3
   } state_t;

   logic        sync1_q, sync2_q;
   state_t      state_q, state_d;
   logic [31:0] deb_cnt_q, deb_cnt_d;
   logic [31:0] str_cnt_q, str_cnt_d;
   logic        rst_out_q, rst_out_d;
   logic        press_q, press_d;
   logic        release_q, release_d;
   logic        down_q, down_d;

   // Two-flop synchroniser; idles at 1 (button not pressed).
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= bus.BTN_N;
         sync2_q <= sync1_q;
      end
   end

   // Debounce FSM: a change is accepted only after the synchronised level holds
   // for the whole window; any return to the old level abandons it silently.
   always_comb begin
      state_d   = state_q;
      deb_cnt_d = deb_cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      down_d    = down_q;
      case (state_q)
         S_UP: begin
            if (!sync2_q) begin
               state_d   = S_DN_WAIT;
               deb_cnt_d = 32'd0;
            end else begin
               state_d   = S_UP;
            end
         end
         S_DN_WAIT: begin
            if (sync2_q) begin
               state_d   = S_UP;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d   = S_DOWN;
               press_d   = 1'b1;
               down_d    = 1'b1;
            end else begin
               deb_cnt_d = deb_cnt_q + 32'd1;
            end
         end
         S_DOWN: begin
            if (sync2_q) begin
               state_d   = S_UP_WAIT;
               deb_cnt_d = 32'd0;
            end else begin
               state_d   = S_DOWN;
            end
         end
         S_UP_WAIT: begin
            if (!sync2_q) begin
               state_d   = S_DOWN;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d   = S_UP;
               release_d = 1'b1;
               down_d    = 1'b0;
            end else begin
               deb_cnt_d = deb_cnt_q + 32'd1;
            end
         end
         default: begin
            state_d   = S_UP;
            deb_cnt_d = 32'd0;
            down_d    = 1'b0;
         end
      endcase
   end

   // Reset stretcher: an accepted press (re)starts the low window from zero,
   // otherwise the counter runs while the output is low and releases it at the end.
   // Coming out of RESET the output is already low with the counter at zero, so
   // the power-on window has the same length as a press window.
   always_comb begin
      rst_out_d = rst_out_q;
      str_cnt_d = str_cnt_q;
      if (press_d) begin
         rst_out_d = 1'b0;
         str_cnt_d = 32'd0;
      end else if (!rst_out_q) begin
         if (str_cnt_q == STR_LAST) begin
            rst_out_d = 1'b1;
            str_cnt_d = 32'd0;
         end else begin
            rst_out_d = 1'b0;
            str_cnt_d = str_cnt_q + 32'd1;
         end
      end else begin
         rst_out_d = 1'b1;
         str_cnt_d = str_cnt_q;
      end
   end

   // State, counters and registered outputs; RESET clears everything at once.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= S_UP;
         deb_cnt_q <= 32'd0;
         str_cnt_q <= 32'd0;
         rst_out_q <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         down_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         deb_cnt_q <= deb_cnt_d;
         str_cnt_q <= str_cnt_d;
         rst_out_q <= rst_out_d;
         press_q   <= press_d;
         release_q <= release_d;
         down_q    <= down_d;
      end
   end

   assign bus.RST_OUT_N = rst_out_q;
   assign bus.PRESS     = press_q;
   assign bus.RELEASE   = release_q;
   assign bus.DOWN      = down_q;

endmodule

// File: tb/tb_button_reset_conditioner.sv
// Directed bench for button_reset_conditioner. Two instances share clock and
// reset: dut_a (debounce 4, stretch 3) and dut_b (debounce 4, stretch 20).
// Output vectors are packed as {RST_OUT_N, PRESS, RELEASE, DOWN}.
module tb_button_reset_conditioner;

   logic clk;
   logic reset_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   button_reset_conditioner_if if_a ();
   button_reset_conditioner_if if_b ();

   button_reset_conditioner #(
      .CLKFREQ(32'd25000000), .DEBOUNCE_CYCLES(32'd4), .STRETCH_CYCLES(32'd3)
   ) dut_a (
      .CLK(clk), .RESET(reset_n), .bus(if_a.master)
   );

   button_reset_conditioner #(
      .CLKFREQ(32'd25000000), .DEBOUNCE_CYCLES(32'd4), .STRETCH_CYCLES(32'd20)
   ) dut_b (
      .CLK(clk), .RESET(reset_n), .bus(if_b.master)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] outs_a();
      return {if_a.RST_OUT_N, if_a.PRESS, if_a.RELEASE, if_a.DOWN};
   endfunction

   function automatic logic [3:0] outs_b();
      return {if_b.RST_OUT_N, if_b.PRESS, if_b.RELEASE, if_b.DOWN};
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   logic [9:0] bounce;
   logic [3:0] g5_exp [6];
   logic [3:0] rs_exp [10];

   initial begin
      bounce = 10'b1100110011;
      g5_exp = '{4'b0001, 4'b0001, 4'b1001, 4'b1001, 4'b1010, 4'b1000};
      rs_exp = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                 4'b0101, 4'b0001, 4'b0001, 4'b1001};

      // Power-on: reset held, then the 3-cycle stretch
      reset_n   = 1'b0;
      if_a.BTN_N = 1'b1;
      if_b.BTN_N = 1'b1;
      repeat (5) step();
      chk("rst_hold_a", outs_a(), 4'b0000);
      chk("rst_hold_b", outs_b(), 4'b0000);
      reset_n = 1'b1;
      step(); chk("por_e1", outs_a(), 4'b0000);
      step(); chk("por_e2", outs_a(), 4'b0000);
      step(); chk("por_e3", outs_a(), 4'b1000);

      // Clean press: first sampling edge N, PRESS after N+6, stretch N+6..N+8
      if_a.BTN_N = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(); chk($sformatf("press_wait_%0d", i), outs_a(), 4'b1000);
      end
      step(); chk("press_pulse", outs_a(), 4'b0101);
      step(); chk("press_str1", outs_a(), 4'b0001);
      step(); chk("press_str2", outs_a(), 4'b0001);
      step(); chk("press_str_end", outs_a(), 4'b1001);

      // Bounce on release: samples 1,1,0,0,1,1,0,0,1,1 then held high
      for (int j = 0; j < 10; j++) begin
         if_a.BTN_N = bounce[j];
         step(); chk($sformatf("bounce_%0d", j), outs_a(), 4'b1001);
      end
      for (int k = 0; k < 4; k++) begin
         step(); chk($sformatf("bounce_settle_%0d", k), outs_a(), 4'b1001);
      end
      step(); chk("bounce_release", outs_a(), 4'b1010);
      step(); chk("bounce_after", outs_a(), 4'b1000);

      // Glitch of 4 low samples: rejected
      if_a.BTN_N = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(); chk($sformatf("glitch4_low_%0d", i), outs_a(), 4'b1000);
      end
      if_a.BTN_N = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(); chk($sformatf("glitch4_after_%0d", i), outs_a(), 4'b1000);
      end

      // 5 low samples: accepted press, then the high level is accepted as release
      if_a.BTN_N = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(); chk($sformatf("glitch5_low_%0d", i), outs_a(), 4'b1000);
      end
      if_a.BTN_N = 1'b1;
      step(); chk("glitch5_n5", outs_a(), 4'b1000);
      step(); chk("glitch5_press", outs_a(), 4'b0101);
      for (int i = 0; i < 6; i++) begin
         step(); chk($sformatf("glitch5_tail_%0d", i), outs_a(), g5_exp[i]);
      end

      // Retrigger on dut_b: second press 12 cycles into a 20-cycle stretch
      chk("b_idle", outs_b(), 4'b1000);
      if_b.BTN_N = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(); chk($sformatf("rt_wait_%0d", i), outs_b(), 4'b1000);
      end
      step(); chk("rt_press1", outs_b(), 4'b0101);
      if_b.BTN_N = 1'b1;
      for (int i = 1; i < 6; i++) begin
         step(); chk($sformatf("rt_down_%0d", i), outs_b(), 4'b0001);
      end
      if_b.BTN_N = 1'b0;
      step(); chk("rt_down_6", outs_b(), 4'b0001);
      step(); chk("rt_release", outs_b(), 4'b0010);
      for (int i = 8; i < 12; i++) begin
         step(); chk($sformatf("rt_up_%0d", i), outs_b(), 4'b0000);
      end
      step(); chk("rt_press2", outs_b(), 4'b0101);
      for (int i = 13; i < 32; i++) begin
         step(); chk($sformatf("rt_hold_%0d", i), outs_b(), 4'b0001);
      end
      step(); chk("rt_end", outs_b(), 4'b1001);
      if_b.BTN_N = 1'b1;

      // Async reset mid-debounce (dut_a in S_DN_WAIT with count 2)
      if_a.BTN_N = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(); chk($sformatf("ar_deb_%0d", i), outs_a(), 4'b1000);
      end
      #3 reset_n = 1'b0;
      #1;
      chk("ar_immediate_a", outs_a(), 4'b0000);
      chk("ar_immediate_b", outs_b(), 4'b0000);
      for (int i = 0; i < 3; i++) begin
         step(); chk($sformatf("ar_held_%0d", i), outs_a(), 4'b0000);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(); chk($sformatf("ar_post_e%0d", i + 1), outs_a(), rs_exp[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
